// File: rtl/xs3_pkg.sv
// Shared constants and types for the Excess-3 decode path.
//   XS3_MIN / XS3_MAX : legal Excess-3 code range (inclusive)
//   XS3_BIAS          : offset removed to recover the BCD digit
//   state_e           : packer FSM states
package xs3_pkg;

  localparam logic [3:0] XS3_MIN  = 4'h3;
  localparam logic [3:0] XS3_MAX  = 4'hC;
  localparam logic [3:0] XS3_BIAS = 4'h3;

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_HOLD    = 1'b1
  } state_e;

endpackage

// File: rtl/xs3_digit_dec.sv
// Combinational Excess-3 to BCD digit decoder.
// Ports:
//   xs3   in  4  Excess-3 code
//   bcd   out 4  decoded BCD digit (0 when the code is illegal)
//   legal out 1  code lies in XS3_MIN..XS3_MAX
module xs3_digit_dec
  import xs3_pkg::*;
(
  input  logic [3:0] xs3,
  output logic [3:0] bcd,
  output logic       legal
);

  assign legal = (xs3 >= XS3_MIN) && (xs3 <= XS3_MAX);
  // Illegal codes collapse to zero so they never leak a bogus digit value.
  assign bcd   = legal ? (xs3 - XS3_BIAS) : 4'h0;

endmodule

// File: rtl/xs3_to_bcd_packer.sv
// Packs a serial stream of Excess-3 digits (most significant first) into a
// right-justified packed BCD word and presents it on a valid/ready port.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     digit input handshake
//   in_xs3, in_last       Excess-3 digit and end-of-word marker
//   out_valid/out_ready   word output handshake
//   out_bcd               packed BCD, digit0 in [3:0]
//   out_ndig              number of digits in the word
//   out_err               at least one illegal code seen in this word
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. A producer holds valid and its payload steady until that
// edge; ready never depends on the same port's valid.
module xs3_to_bcd_packer
  import xs3_pkg::*;
#(
  parameter  int NDIGITS = 4,
  localparam int CW      = $clog2(NDIGITS + 1),
  localparam int W       = 4 * NDIGITS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_xs3,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_bcd,
  output logic [CW-1:0] out_ndig,
  output logic          out_err
);

  localparam logic [CW-1:0] CNT_MAX = CW'(NDIGITS);

  state_e        state, state_nxt;
  logic [W-1:0]  acc, acc_nxt, acc_shift;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic          err, err_nxt;
  logic [3:0]    dig_bcd;
  logic          dig_legal;

  xs3_digit_dec u_dec (
    .xs3   (in_xs3),
    .bcd   (dig_bcd),
    .legal (dig_legal)
  );

  // A single-digit word has no upper digits to shift along.
  if (NDIGITS == 1) begin : g_one
    assign acc_shift = dig_bcd;
  end else begin : g_multi
    assign acc_shift = {acc[W-5:0], dig_bcd};
  end

  assign cnt_inc = cnt + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_COLLECT;
      acc   <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    err_nxt   = err;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_COLLECT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_nxt = acc_shift;
          cnt_nxt = cnt_inc;
          err_nxt = err | ~dig_legal;
          // A full word closes regardless of in_last.
          if ((cnt_inc == CNT_MAX) || in_last) state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          acc_nxt   = '0;
          cnt_nxt   = '0;
          err_nxt   = 1'b0;
          state_nxt = S_COLLECT;
        end
      end
      default: state_nxt = S_COLLECT;
    endcase
  end

  // Word fields come straight from registers, so they hold steady in HOLD.
  assign out_bcd  = acc;
  assign out_ndig = cnt;
  assign out_err  = err;

endmodule

// File: tb/tb_xs3_to_bcd_packer.sv
module tb_xs3_to_bcd_packer;

  localparam int ND = 4;
  localparam int W  = 4 * ND;
  localparam int CW = $clog2(ND + 1);
  localparam int EW = W + CW + 1;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT (NDIGITS=4) ----------------
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_xs3   = 4'h0;
  logic          in_last  = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_bcd;
  logic [CW-1:0] out_ndig;
  logic          out_err;

  xs3_to_bcd_packer #(.NDIGITS(ND)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_xs3    (in_xs3),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
    .out_ndig  (out_ndig),
    .out_err   (out_err)
  );

  // ---------------- DUT (NDIGITS=1) ----------------
  logic       v1 = 1'b0;
  logic       r1;
  logic [3:0] x1 = 4'h0;
  logic       l1 = 1'b0;
  logic       ov1;
  logic       ordy1 = 1'b0;
  logic [3:0] bcd1;
  logic [0:0] nd1;
  logic       er1;

  xs3_to_bcd_packer #(.NDIGITS(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v1),
    .in_ready  (r1),
    .in_xs3    (x1),
    .in_last   (l1),
    .out_valid (ov1),
    .out_ready (ordy1),
    .out_bcd   (bcd1),
    .out_ndig  (nd1),
    .out_err   (er1)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0]    dig_q[$];
  logic [EW-1:0] exp_q[$];   // {err, ndig, bcd}

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_tests++;
    n_fail++;
    $display("FAIL %s: no handshake within cycle budget", tag);
  endtask

  // Reference: decimal digits accumulated by place value.
  function automatic logic [EW-1:0] model_word();
    int unsigned   val = 0;
    logic          e   = 1'b0;
    logic [CW-1:0] nd;
    foreach (dig_q[i]) begin
      int c = int'(dig_q[i]);
      if (c >= 3 && c <= 12) val = val * 16 + (c - 3);
      else begin
        val = val * 16;
        e   = 1'b1;
      end
    end
    nd = CW'(dig_q.size());
    return {e, nd, W'(val)};
  endfunction

  function automatic logic [3:0] model_digit(input int c);
    return (c >= 3 && c <= 12) ? 4'(c - 3) : 4'h0;
  endfunction

  // ---------------- drivers ----------------
  // All tasks enter and leave at one time unit after a rising edge.
  task automatic send_digit(input logic [3:0] code, input logic last);
    int   k = 0;
    logic rdy;
    in_valid = 1'b1;
    in_xs3   = code;
    in_last  = last;
    forever begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      k++;
      if (k >= 50) begin
        timeout("in_handshake");
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_word(input bit use_last, input bit gaps);
    exp_q.push_back(model_word());
    foreach (dig_q[i]) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send_digit(dig_q[i], use_last && (i == dig_q.size() - 1));
    end
    check("latency_out_valid", out_valid, 1);
    check("latency_in_ready", in_ready, 0);
  endtask

  task automatic collect_word(input int delay);
    logic [EW-1:0] exp;
    exp = exp_q.pop_front();
    check("out_bcd", out_bcd, exp[W-1:0]);
    check("out_ndig", out_ndig, exp[W+CW-1:W]);
    check("out_err", out_err, exp[EW-1]);
    repeat (delay) begin
      @(posedge clk);
      #1;
      check("hold_stable", {out_err, out_ndig, out_bcd}, exp);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("out_valid_drop", out_valid, 0);
    check("in_ready_back", in_ready, 1);
  endtask

  task automatic load(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                      input logic [3:0] d, input int n);
    logic [3:0] t[4];
    t = '{a, b, c, d};
    dig_q.delete();
    for (int i = 0; i < n; i++) dig_q.push_back(t[i]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_bcd", out_bcd, 0);
    check("rst_out_ndig", out_ndig, 0);
    check("rst_out_err", out_err, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);

    // Full word
    load(4'h7, 4'h8, 4'h4, 4'hC, 4);
    send_word(1, 0);
    check("full_word_const", out_bcd, 16'h4519);
    collect_word(0);

    // Early terminate
    load(4'h3, 4'hC, 4'h0, 4'h0, 2);
    send_word(1, 0);
    check("early_const", out_bcd, 16'h0009);
    collect_word(0);

    // Illegal codes, then a clean word clears the flag
    load(4'h7, 4'hF, 4'h2, 4'h5, 4);
    send_word(0, 0);
    check("illegal_const", out_bcd, 16'h4002);
    check("illegal_err", out_err, 1);
    collect_word(0);
    load(4'h5, 4'h6, 4'h7, 4'h8, 4);
    send_word(0, 0);
    check("err_cleared", out_err, 0);
    collect_word(0);

    // Backpressure with a digit offered during HOLD
    load(4'h9, 4'hA, 4'hB, 4'h3, 4);
    send_word(1, 1);
    in_valid = 1'b1;
    in_xs3   = 4'h5;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_stable", {out_err, out_ndig, out_bcd}, exp_q[0]);
    end
    in_valid = 1'b0;
    collect_word(0);

    // Reset mid-word
    send_digit(4'h8, 0);
    send_digit(4'h9, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_bcd", out_bcd, 0);
    check("mid_rst_ndig", out_ndig, 0);
    check("mid_rst_err", out_err, 0);
    check("mid_rst_valid", out_valid, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    load(4'h4, 4'h4, 4'h4, 4'h4, 4);
    send_word(0, 0);
    check("post_rst_const", out_bcd, 16'h1111);
    check("post_rst_ndig", out_ndig, 4);
    collect_word(0);

    // Randomised words
    for (int w = 0; w < 40; w++) begin
      int  n  = $urandom_range(1, ND);
      bit  ul = (n < ND) ? 1'b1 : 1'($urandom_range(0, 1));
      dig_q.delete();
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) dig_q.push_back(4'($urandom_range(0, 15)));
        else dig_q.push_back(4'($urandom_range(3, 12)));
      end
      send_word(ul, 1);
      collect_word($urandom_range(0, 3));
    end

    // NDIGITS=1: every code produces its own word
    for (int c = 0; c < 16; c++) begin
      int k = 0;
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      v1 = 1'b1;
      x1 = 4'(c);
      l1 = 1'($urandom_range(0, 1));
      forever begin
        logic rdy;
        @(negedge clk);
        rdy = r1;
        @(posedge clk);
        #1;
        if (rdy) break;
        k++;
        if (k >= 50) begin
          timeout("nd1_handshake");
          break;
        end
      end
      v1 = 1'b0;
      l1 = 1'b0;
      check("nd1_valid", ov1, 1);
      check("nd1_bcd", bcd1, model_digit(c));
      check("nd1_ndig", nd1, 1);
      check("nd1_err", er1, (c < 3 || c > 12) ? 1 : 0);
      ordy1 = 1'b1;
      @(posedge clk);
      #1;
      ordy1 = 1'b0;
      check("nd1_drop", ov1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
